// File: rtl/rx_multi_out.sv
// rx_multi_out: groups one captured I/Q sample per enabled channel into a round, buffers rounds in a shared FIFO, reads out 16-bit words.
// Latency: trigger to first FIFO write is 2 cycles; a round that does not fit is dropped whole. Backpressure: none upstream, the host pops at will.
// Optional: RX_MULTI_OUT_SEQ_TAG_EN prefixes every accepted round with a sequence/mask header entry.
module rx_multi_out #(
  parameter int NCH      = 4,
  parameter int RXO_BITS = 24,
  parameter int DEPTH    = 64
) (
  input  logic                     adc_clk,
  input  logic                     reset_n,
  input  logic [NCH-1:0]           ch_avail,
  input  logic [NCH*RXO_BITS-1:0]  ch_i,
  input  logic [NCH*RXO_BITS-1:0]  ch_q,
  input  logic                     set_chan_en,
  input  logic [NCH-1:0]           chan_en_in,
  input  logic                     rd_word,
  input  logic                     clr_status,
  output logic [15:0]              dout,
  output logic                     dout_valid,
  output logic [$clog2(DEPTH):0]   fill,
  output logic [NCH-1:0]           overrun,
  output logic                     overflow,
  output logic [15:0]              drop_cnt
);
  localparam int AW  = $clog2(DEPTH);
  localparam int EW  = 2 * RXO_BITS;
  localparam int WPS = (RXO_BITS == 24) ? 3 : 2;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

  if (RXO_BITS != 16 && RXO_BITS != 24) begin : g_bad_width
    $error("rx_multi_out: RXO_BITS must be 16 or 24");
  end

  typedef enum logic [1:0] {IDLE, CHECK, PUSH, HDR} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cur_ch_q, cur_ch_d;
  logic [NCH-1:0]        chan_en_q, chan_en_d, en_next_q, en_next_d;
  logic                  en_upd_q, en_upd_d;
  logic [NCH-1:0]        pending_q, pending_d;
  logic [RXO_BITS-1:0]   hold_i_q [NCH], hold_i_d [NCH];
  logic [RXO_BITS-1:0]   hold_q_q [NCH], hold_q_d [NCH];
  logic [NCH-1:0]        overrun_q, overrun_d;
  logic                  overflow_q, overflow_d;
  logic [15:0]           drop_cnt_q, drop_cnt_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]           fill_q, fill_d;
  logic [1:0]            widx_q, widx_d;
  logic [15:0]           seq_q, seq_d;
  logic [EW-1:0]         mem_q [DEPTH];

  logic                  wr_en, rd_fire, pop, trigger, round_done;
  logic [EW-1:0]         wr_dat, head;
  logic [23:0]           head_i, head_q;
  logic [AW+1:0]         need, free;

  function automatic logic [CW-1:0] first_en(input logic [NCH-1:0] mask, input int from);
    first_en = '0;
    for (int c = NCH - 1; c >= 0; c--) begin
      if (mask[c] && c >= from) first_en = CW'(c);
    end
  endfunction

  function automatic logic more_en(input logic [NCH-1:0] mask, input int from);
    more_en = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (mask[c] && c >= from) more_en = 1'b1;
    end
  endfunction

  always_comb begin
    need = '0;
    for (int c = 0; c < NCH; c++) need = need + (AW+2)'(chan_en_q[c]);
`ifdef RX_MULTI_OUT_SEQ_TAG_EN
    need = need + (AW+2)'(1);
`endif
  end
  assign free = (AW+2)'(DEPTH) - (AW+2)'(fill_q);

  assign trigger = (state_q == IDLE) && (pending_q == chan_en_q) && (chan_en_q != '0);

  always_comb begin
    state_d    = state_q;
    cur_ch_d   = cur_ch_q;
    chan_en_d  = chan_en_q;
    en_next_d  = en_next_q;
    en_upd_d   = en_upd_q;
    pending_d  = pending_q;
    hold_i_d   = hold_i_q;
    hold_q_d   = hold_q_q;
    overrun_d  = overrun_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    seq_d      = seq_q;
    wr_en      = 1'b0;
    wr_dat     = '0;
    round_done = 1'b0;

    if (clr_status) begin
      overrun_d  = '0;
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end

    for (int c = 0; c < NCH; c++) begin
      if (ch_avail[c] && chan_en_q[c]) begin
        if (pending_q[c]) begin
          overrun_d[c] = 1'b1;
        end else begin
          pending_d[c] = 1'b1;
          hold_i_d[c]  = ch_i[c*RXO_BITS +: RXO_BITS];
          hold_q_d[c]  = ch_q[c*RXO_BITS +: RXO_BITS];
        end
      end
    end

    case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d = CHECK;
        end else if (en_upd_q) begin
          // Mask swaps only between rounds; half-collected samples belong to the old mask.
          chan_en_d = en_next_q;
          pending_d = '0;
          en_upd_d  = 1'b0;
        end
      end
      CHECK: begin
        if (free >= need) begin
`ifdef RX_MULTI_OUT_SEQ_TAG_EN
          state_d = HDR;
`else
          state_d = PUSH;
`endif
          cur_ch_d = first_en(chan_en_q, 0);
        end else begin
          pending_d  = '0;
          overflow_d = 1'b1;
          if (drop_cnt_d != 16'hFFFF) drop_cnt_d = drop_cnt_d + 16'd1;
          round_done = 1'b1;
          state_d    = IDLE;
        end
      end
      HDR: begin
        wr_en   = 1'b1;
        wr_dat  = {RXO_BITS'(seq_q), RXO_BITS'({8'hA5, 8'(chan_en_q)})};
        state_d = PUSH;
      end
      PUSH: begin
        wr_en               = 1'b1;
        wr_dat              = {hold_i_q[cur_ch_q], hold_q_q[cur_ch_q]};
        pending_d[cur_ch_q] = 1'b0;
        if (more_en(chan_en_q, int'(cur_ch_q) + 1)) begin
          cur_ch_d = first_en(chan_en_q, int'(cur_ch_q) + 1);
        end else begin
          round_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (set_chan_en) begin
      en_next_d = chan_en_in;
      en_upd_d  = 1'b1;
    end
`ifdef RX_MULTI_OUT_SEQ_TAG_EN
    if (round_done) seq_d = seq_q + 16'd1;
`endif
  end

  assign rd_fire  = rd_word && (fill_q != '0);
  assign pop      = rd_fire && (widx_q == 2'(WPS - 1));
  assign widx_d   = pop ? 2'd0 : (rd_fire ? widx_q + 2'd1 : widx_q);
  assign wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
  assign rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
  assign fill_d   = fill_q + (AW+1)'(wr_en) - (AW+1)'(pop);

  assign head   = mem_q[rd_ptr_q];
  assign head_i = 24'(head[EW-1:RXO_BITS]);
  assign head_q = 24'(head[RXO_BITS-1:0]);

  always_comb begin
    dout = '0;
    if (fill_q != '0) begin
      case (widx_q)
        2'd0:    dout = head_i[15:0];
        2'd1:    dout = head_q[15:0];
        default: dout = {head_i[23:16], head_q[23:16]};
      endcase
    end
  end

  always_ff @(posedge adc_clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_dat;
  end

  always_ff @(posedge adc_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cur_ch_q   <= '0;
      chan_en_q  <= '0;
      en_next_q  <= '0;
      en_upd_q   <= 1'b0;
      pending_q  <= '0;
      hold_i_q   <= '{default: '0};
      hold_q_q   <= '{default: '0};
      overrun_q  <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      widx_q     <= '0;
      seq_q      <= '0;
    end else begin
      state_q    <= state_d;
      cur_ch_q   <= cur_ch_d;
      chan_en_q  <= chan_en_d;
      en_next_q  <= en_next_d;
      en_upd_q   <= en_upd_d;
      pending_q  <= pending_d;
      hold_i_q   <= hold_i_d;
      hold_q_q   <= hold_q_d;
      overrun_q  <= overrun_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      widx_q     <= widx_d;
      seq_q      <= seq_d;
    end
  end

  assign dout_valid = (fill_q != '0);
  assign fill       = fill_q;
  assign overrun    = overrun_q;
  assign overflow   = overflow_q;
  assign drop_cnt   = drop_cnt_q;
endmodule
